alu_req_driver: RTL and testbench

- Sequential initiator for the combinational 32-bit ALU (sel/opA/opB in; res/z/c/v out).
- Accepts one operation request per transaction over a valid/ready handshake and drives registered operands into the ALU.
- Waits a programmable settle time, then captures the result and flags and returns them over a valid/ready response handshake.
- Rejects opcodes the ALU does not implement and keeps sticky status flags plus an operation counter for the control/status logic.

---
 rtl/alu_req_driver_pkg.sv | 22 ++
 rtl/alu_req_driver_if.sv | 55 +++++
 rtl/alu_req_driver.sv | 126 ++++++++++++
 tb/tb_alu_req_driver.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_req_driver_pkg.sv
// Shared definitions for the ALU request driver, the ALU and their benches:
// opcode encodings, opcode legality and the driver FSM state encoding.
package alu_req_driver_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StResp
  } drv_state_e;

  // Legal opcodes occupy the encodings from OP_ADD up to and including OP_NOT.
  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= OP_NOT;
  endfunction

endpackage

// File: rtl/alu_req_driver_if.sv
// Request, ALU-side, response and status signals of the ALU request driver.
// The master modport is the driver; the slave modport is its environment.
interface alu_req_driver_if #(
  parameter int unsigned CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;

  logic [2:0]       alu_sel;
  logic [31:0]      alu_opa;
  logic [31:0]      alu_opb;
  logic [31:0]      alu_res;
  logic             alu_z;
  logic             alu_c;
  logic             alu_v;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_res;
  logic             rsp_z;
  logic             rsp_c;
  logic             rsp_v;
  logic             rsp_err;

  logic             clr_sticky;
  logic             sticky_z;
  logic             sticky_c;
  logic             sticky_v;
  logic [CNT_W-1:0] op_count;

  modport master (
    input  req_valid, req_op, req_a, req_b,
    output req_ready,
    output alu_sel, alu_opa, alu_opb,
    input  alu_res, alu_z, alu_c, alu_v,
    output rsp_valid, rsp_res, rsp_z, rsp_c, rsp_v, rsp_err,
    input  rsp_ready,
    input  clr_sticky,
    output sticky_z, sticky_c, sticky_v, op_count
  );

  modport slave (
    output req_valid, req_op, req_a, req_b,
    input  req_ready,
    input  alu_sel, alu_opa, alu_opb,
    output alu_res, alu_z, alu_c, alu_v,
    input  rsp_valid, rsp_res, rsp_z, rsp_c, rsp_v, rsp_err,
    output rsp_ready,
    output clr_sticky,
    input  sticky_z, sticky_c, sticky_v, op_count
  );
endinterface

// File: rtl/alu_req_driver.sv
// Sequential initiator for the combinational ALU: registers one request onto the ALU inputs,
// waits SETTLE_CYCLES, captures result/flags and returns them; keeps sticky flags and a counter.
module alu_req_driver
  import alu_req_driver_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input logic              clk,
  input logic              rst,
  alu_req_driver_if.master bus
);

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  drv_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic [31:0]      res_q, res_d;
  logic [2:0]       flags_q, flags_d;   // {z, c, v}
  logic             err_q, err_d;
  logic [2:0]       sticky_q, sticky_d; // {z, c, v}
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    flags_d  = flags_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    count_d  = count_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (is_legal_op(bus.req_op)) begin
            sel_d   = bus.req_op;
            opa_d   = bus.req_a;
            opb_d   = bus.req_b;
            cnt_d   = SettleLoad;
            state_d = StSettle;
          end else begin
            // Illegal ops never reach the ALU; its inputs keep the previous operation.
            res_d   = '0;
            flags_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          res_d   = bus.alu_res;
          flags_d = {bus.alu_z, bus.alu_c, bus.alu_v};
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
          if (!err_q) begin
            count_d  = count_q + CNT_W'(1);
            sticky_d = sticky_q | flags_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Clear takes priority over a same-cycle sticky update.
    if (bus.clr_sticky) begin
      sticky_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sel_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.alu_sel   = sel_q;
  assign bus.alu_opa   = opa_q;
  assign bus.alu_opb   = opb_q;
  assign bus.rsp_res   = res_q;
  assign bus.rsp_z     = flags_q[2];
  assign bus.rsp_c     = flags_q[1];
  assign bus.rsp_v     = flags_q[0];
  assign bus.rsp_err   = err_q;
  assign bus.sticky_z  = sticky_q[2];
  assign bus.sticky_c  = sticky_q[1];
  assign bus.sticky_v  = sticky_q[0];
  assign bus.op_count  = count_q;

endmodule

// File: tb/tb_alu_req_driver.sv
// Bench for alu_req_driver: two instances (settle 1 / 16-bit count, settle 4 / 2-bit count)
// each driving a behavioural ALU; directed vectors plus handshake corner sequences.
module tb_alu_req_driver;
  import alu_req_driver_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2;
  int   checks = 0;
  int   errors = 0;

  alu_req_driver_if #(.CNT_W(16)) b1 ();
  alu_req_driver_if #(.CNT_W(2))  b2 ();

  alu_req_driver #(.SETTLE_CYCLES(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst1), .bus(b1.master));
  alu_req_driver #(.SETTLE_CYCLES(4), .CNT_W(2))  dut2 (.clk(clk), .rst(rst2), .bus(b2.master));

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
  } alu_out_t;

  // Behavioural ALU: c is carry-out for ADD and borrow for SUB; logic ops clear c and v.
  function automatic alu_out_t alu_f(input logic [2:0] sel, input logic [31:0] a,
                                     input logic [31:0] b);
    alu_out_t    o;
    logic [32:0] w;
    o = '0;
    case (sel)
      OP_ADD: begin
        w     = {1'b0, a} + {1'b0, b};
        o.res = w[31:0];
        o.c   = w[32];
        o.v   = (a[31] == b[31]) && (o.res[31] != a[31]);
      end
      OP_SUB: begin
        w     = {1'b0, a} - {1'b0, b};
        o.res = w[31:0];
        o.c   = w[32];
        o.v   = (a[31] != b[31]) && (o.res[31] != a[31]);
      end
      OP_AND:  o.res = a & b;
      OP_OR:   o.res = a | b;
      OP_NOT:  o.res = ~a;
      default: o.res = '0;
    endcase
    o.z = (o.res == 32'd0);
    return o;
  endfunction

  alu_out_t a1, a2;
  assign a1 = alu_f(b1.alu_sel, b1.alu_opa, b1.alu_opb);
  assign a2 = alu_f(b2.alu_sel, b2.alu_opa, b2.alu_opb);
  assign b1.alu_res = a1.res;
  assign b1.alu_z   = a1.z;
  assign b1.alu_c   = a1.c;
  assign b1.alu_v   = a1.v;
  assign b2.alu_res = a2.res;
  assign b2.alu_z   = a2.z;
  assign b2.alu_c   = a2.c;
  assign b2.alu_v   = a2.v;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  zcve; // {z, c, v, err}
  } vec_t;

  vec_t        vecs [11];
  logic [2:0]  m_sticky;
  logic [15:0] m_count;
  logic [1:0]  m_count2;
  logic [2:0]  m_last_sel;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp1(output int lat);
    lat = 1;
    while (!b1.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec1(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    chk($sformatf("vec%0d req_ready", idx), 64'(b1.req_ready), 64'd1);
    b1.req_valid = 1'b1;
    b1.req_op    = v.op;
    b1.req_a     = v.a;
    b1.req_b     = v.b;
    b1.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.req_valid = 1'b0;
    wait_rsp1(lat);
    chk($sformatf("vec%0d latency", idx), 64'(lat), v.zcve[0] ? 64'd1 : 64'd2);
    chk($sformatf("vec%0d rsp_res", idx), 64'(b1.rsp_res), 64'(v.res));
    chk($sformatf("vec%0d flags", idx),
        64'({b1.rsp_z, b1.rsp_c, b1.rsp_v, b1.rsp_err, b1.req_ready}), 64'({v.zcve, 1'b0}));
    if (!v.zcve[0]) m_last_sel = v.op;
    chk($sformatf("vec%0d alu_sel", idx), 64'(b1.alu_sel), 64'(m_last_sel));
    @(negedge clk);
    if (!v.zcve[0]) begin
      m_count  = m_count + 16'd1;
      m_sticky = m_sticky | v.zcve[3:1];
    end
    chk($sformatf("vec%0d post", idx),
        64'({b1.rsp_valid, b1.sticky_z, b1.sticky_c, b1.sticky_v, b1.op_count}),
        64'({1'b0, m_sticky, m_count}));
  endtask

  // Runs one op on dut2 with rsp_ready high; checks alu hold during settle and the response.
  task automatic run2(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic z, input string name);
    int lat;
    @(negedge clk);
    b2.req_valid = 1'b1;
    b2.req_op    = op;
    b2.req_a     = a;
    b2.req_b     = b;
    b2.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b2.req_valid = 1'b0;
    b2.req_a     = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s settle%0d", name, i),
          64'({b2.rsp_valid, b2.req_ready, b2.alu_sel, b2.alu_opa == a, b2.alu_opb == b}),
          64'({2'b00, op, 2'b11}));
      @(negedge clk);
    end
    lat = 5;
    while (!b2.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'd5);
    chk({name, " rsp"}, 64'({b2.rsp_res, b2.rsp_z, b2.rsp_err}), 64'({res, z, 1'b0}));
    @(negedge clk);
    m_count2 = m_count2 + 2'd1;
    chk({name, " op_count"}, 64'({b2.rsp_valid, b2.op_count}), 64'({1'b0, m_count2}));
  endtask

  initial begin
    int lat;
    logic seen;

    vecs[0]  = '{OP_ADD, 32'd5,          32'd3,        32'd8,          4'b0000};
    vecs[1]  = '{OP_ADD, 32'h7FFF_FFFF,  32'd1,        32'h8000_0000,  4'b0010};
    vecs[2]  = '{OP_SUB, 32'd10,         32'd10,       32'd0,          4'b1000};
    vecs[3]  = '{OP_AND, 32'hF0,         32'h0F,       32'd0,          4'b1000};
    vecs[4]  = '{OP_OR,  32'hF0,         32'h0F,       32'hFF,         4'b0000};
    vecs[5]  = '{OP_NOT, 32'd0,          32'h1234,     32'hFFFF_FFFF,  4'b0000};
    vecs[6]  = '{3'b110, 32'd9,          32'd9,        32'd0,          4'b0001};
    vecs[7]  = '{OP_ADD, 32'hFFFF_FFFF,  32'd1,        32'd0,          4'b1100};
    vecs[8]  = '{OP_SUB, 32'h8000_0000,  32'd1,        32'h7FFF_FFFF,  4'b0010};
    vecs[9]  = '{3'b111, 32'd1,          32'd1,        32'd0,          4'b0001};
    vecs[10] = '{OP_SUB, 32'd1,          32'd2,        32'hFFFF_FFFF,  4'b0100};

    m_sticky   = '0;
    m_count    = '0;
    m_count2   = '0;
    m_last_sel = '0;
    rst1 = 1'b1;
    rst2 = 1'b1;
    b1.req_valid = 1'b0; b1.req_op = '0; b1.req_a = '0; b1.req_b = '0;
    b1.rsp_ready = 1'b0; b1.clr_sticky = 1'b0;
    b2.req_valid = 1'b0; b2.req_op = '0; b2.req_a = '0; b2.req_b = '0;
    b2.rsp_ready = 1'b0; b2.clr_sticky = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    rst2 = 1'b0;

    chk("reset hs", 64'({b1.req_ready, b1.rsp_valid, b1.rsp_err, b1.rsp_z, b1.rsp_c, b1.rsp_v}),
        64'b100000);
    chk("reset alu", 64'({b1.alu_sel, b1.alu_opa | b1.alu_opb, b1.rsp_res}), 64'd0);
    chk("reset status", 64'({b1.sticky_z, b1.sticky_c, b1.sticky_v, b1.op_count}), 64'd0);

    for (int i = 0; i < 11; i++) run_vec1(vecs[i], i);

    // Backpressure: response must hold for five stalled cycles.
    @(negedge clk);
    b1.rsp_ready = 1'b0;
    b1.req_valid = 1'b1;
    b1.req_op    = OP_AND;
    b1.req_a     = 32'hF0;
    b1.req_b     = 32'h0F;
    @(posedge clk);
    @(negedge clk);
    b1.req_valid = 1'b0;
    wait_rsp1(lat);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d", i),
          64'({b1.rsp_valid, b1.req_ready, b1.rsp_res, b1.rsp_z, b1.rsp_c, b1.rsp_v, b1.rsp_err}),
          64'({2'b10, 32'd0, 4'b1000}));
      @(negedge clk);
    end
    b1.rsp_ready = 1'b1;
    @(negedge clk);
    m_count  = m_count + 16'd1;
    m_sticky = m_sticky | 3'b100;
    chk("stall release", 64'({b1.rsp_valid, b1.op_count}), 64'({1'b0, m_count}));

    // Explicit clear.
    b1.clr_sticky = 1'b1;
    @(negedge clk);
    b1.clr_sticky = 1'b0;
    m_sticky = '0;
    chk("clr sticky", 64'({b1.sticky_z, b1.sticky_c, b1.sticky_v}), 64'd0);

    // Clear in the same cycle as an overflow response handshake: clear wins.
    b1.rsp_ready = 1'b0;
    b1.req_valid = 1'b1;
    b1.req_op    = OP_ADD;
    b1.req_a     = 32'h7FFF_FFFF;
    b1.req_b     = 32'd1;
    @(posedge clk);
    @(negedge clk);
    b1.req_valid = 1'b0;
    wait_rsp1(lat);
    b1.rsp_ready  = 1'b1;
    b1.clr_sticky = 1'b1;
    @(negedge clk);
    b1.clr_sticky = 1'b0;
    m_count = m_count + 16'd1;
    chk("clr collision", 64'({b1.sticky_z, b1.sticky_c, b1.sticky_v, b1.op_count}),
        64'({3'b000, m_count}));

    // Four-cycle settle, then 2-bit counter wrap.
    run2(OP_SUB, 32'd10, 32'd10, 32'd0, 1'b1, "settle4 sub");
    run2(OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, "wrap1");
    run2(OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, "wrap2");
    run2(OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, "wrap3");

    // Reset during settle drops the transaction.
    @(negedge clk);
    b2.req_valid = 1'b1;
    b2.req_op    = OP_ADD;
    b2.req_a     = 32'd5;
    b2.req_b     = 32'd3;
    @(posedge clk);
    @(negedge clk);
    b2.req_valid = 1'b0;
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    chk("rst settle hs", 64'({b2.rsp_valid, b2.req_ready, b2.op_count}), 64'b0100);
    chk("rst settle alu", 64'({b2.alu_sel, b2.alu_opa | b2.alu_opb, b2.rsp_res}), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b2.rsp_valid) seen = 1'b1;
    end
    chk("rst no response", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
